qsram_array_refresh: RTL and testbench
======================================

# qsram_array_refresh

Parametrised quasi-static RAM array: DEPTH rows of WIDTH-bit cells that lose their contents unless written or refreshed within RETENTION cycles, with a built-in round-robin refresh controller. It is the array-level successor to the single QSRAM cell. It sits between a single-port requester and the storage, stalling requests (Ready low) during the one-cycle refresh slots it inserts. Cell decay is modelled per row so that retention violations are observable at the read port.

## Interface
- WIDTH, 8: data bits per row.
- DEPTH, 16: number of rows (≥2); AW = $clog2(DEPTH).
- REFRESH_INTERVAL, 8: cycles between refresh slots (≥2).
- RETENTION, 256: cycles a row holds data without write/refresh. Legal only if REFRESH_INTERVAL*DEPTH < RETENTION.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- RefreshEnable  in  1  1 = controller inserts refresh slots; 0 = refresh suppressed (retention test mode).
- Address  in  AW  row for read/write.
- inputData  in  WIDTH  write data.
- WriteEdge  in  1  write request.
- ReadEdge  in  1  read request.
- Ready  out  1  requests sampled at this edge are accepted.
- outputData  out  WIDTH  read data.
- OutputValid  out  1  one-cycle strobe, outputData valid.
- DataLost  out  1  qualifies OutputValid: row had expired, outputData forced 0.
- RefreshActive  out  1  current cycle is a refresh slot.
- RefreshRow  out  AW  row refreshed in the current slot / next row to refresh.

## Operation
- Per row: data register, age counter (saturating at RETENTION), expired flag.
- Every cycle each row's age increments by 1 unless written/refreshed that cycle; when age reaches RETENTION the expired flag sets; contents no longer trusted.
- Controller states: IDLE, REFRESH.
  - IntervalCount increments every cycle (including REFRESH cycles and while RefreshEnable=0), wraps at REFRESH_INTERVAL-1.
  - IDLE→REFRESH on the wrap edge when RefreshEnable=1; REFRESH→IDLE unconditionally after one cycle.
  - In REFRESH: row RefreshRow age←0 (expired flag unchanged; lost data is not recovered), RefreshRow←(RefreshRow+1) mod DEPTH at end of slot.
- Ready = (state==IDLE), combinational from state only.
- Write (WriteEdge & Ready): data←inputData, age←0, expired←0.
- Read (ReadEdge & Ready): outputData←expired ? 0 : data; DataLost←expired; OutputValid←1 next cycle.
- Read and write same cycle: both accepted; write to a different address is independent; same address returns old data (read-before-write), including old expired status.
- Requests while Ready=0 are ignored; requester holds them until Ready=1.
- Write to the row being refreshed cannot occur (Ready=0).

## Timing
- Reset (async assert): state IDLE, IntervalCount 0, RefreshRow 0, all data 0, all ages 0, all rows expired=1; outputs: Ready 1, outputData 0, OutputValid 0, DataLost 0, RefreshActive 0.
- Read latency 1: request at edge k → outputData/OutputValid/DataLost valid after edge k, OutputValid drops after edge k+1 unless re-read; outputData holds last value between reads.
- Write visible to a read accepted at edge k+1.
- First refresh slot: with RefreshEnable=1 from reset, IntervalCount wraps at edge REFRESH_INTERVAL-1 → RefreshActive high during cycle REFRESH_INTERVAL; slots then every REFRESH_INTERVAL cycles.
- Worst-case gap between refreshes of one row = REFRESH_INTERVAL*DEPTH cycles < RETENTION ⇒ no loss under continuous enable.
- RefreshRow wraps DEPTH-1→0.
- Reset mid-REFRESH: slot aborted, row state reinitialised as above.
- RefreshEnable deasserted on the wrap edge: no slot; already-entered slot completes.

## Test plan
- Reset, read Address 3 → after 1 cycle outputData 0x00, OutputValid 1, DataLost 1.
- Write 0xA5 to row 2, read row 2 next cycle → outputData 0xA5, DataLost 0, OutputValid single-cycle pulse.
- DEPTH=4, REFRESH_INTERVAL=4, RefreshEnable=1 → RefreshActive/Ready low at cycles 4,8,12,16,20; RefreshRow 0,1,2,3,0; request held across a slot accepted at following cycle.
- RefreshEnable=0, RETENTION=32: write 0x3C row 1, read at 31 cycles → 0x3C; read at 32 cycles → 0x00, DataLost 1; with RefreshEnable=1 (REFRESH_INTERVAL=4, DEPTH=4), read after 200 cycles → 0x3C.
- Row 5 holds 0x11; same-cycle write 0x22 + read row 5 → returns 0x11; next read → 0x22.
- Assert Reset during a REFRESH cycle → Ready 1, RefreshActive 0, RefreshRow 0 immediately; subsequent read of any row → 0x00, DataLost 1.

Source files
------------

// File: rtl/qsram_array_refresh.sv
// Quasi-static RAM array with per-row decay model and a round-robin refresh controller.
// Refresh slots steal one cycle each, during which the requester sees Ready low.
module qsram_array_refresh #(
   parameter int WIDTH            = 8,
   parameter int DEPTH            = 16,
   parameter int REFRESH_INTERVAL = 8,
   parameter int RETENTION        = 256,
   localparam int AW              = $clog2(DEPTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             RefreshEnable,
   input  logic [AW-1:0]    Address,
   input  logic [WIDTH-1:0] inputData,
   input  logic             WriteEdge,
   input  logic             ReadEdge,
   output logic             Ready,
   output logic [WIDTH-1:0] outputData,
   output logic             OutputValid,
   output logic             DataLost,
   output logic             RefreshActive,
   output logic [AW-1:0]    RefreshRow
);

   localparam int IW  = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam int AGW = $clog2(RETENTION + 1);

   typedef enum logic {IDLE, REFRESH} state_t;

   state_t           r_state;
   logic [IW-1:0]    r_intervalCount;
   logic [AW-1:0]    r_refreshRow;
   logic [WIDTH-1:0] r_data    [DEPTH];
   logic [AGW-1:0]   r_age     [DEPTH];
   logic             r_expired [DEPTH];
   logic [WIDTH-1:0] r_outData;
   logic             r_outValid;
   logic             r_dataLost;

   logic w_ready;
   logic w_wrAccept;
   logic w_rdAccept;
   logic w_wrap;
   logic w_rowLost;

   assign w_ready    = (r_state == IDLE);
   assign w_wrAccept = WriteEdge & w_ready;
   assign w_rdAccept = ReadEdge & w_ready;
   assign w_wrap     = (r_intervalCount == IW'(REFRESH_INTERVAL - 1));
   // A row whose age hits RETENTION at this very edge has already decayed when sensed.
   assign w_rowLost  = r_expired[Address] | (r_age[Address] >= AGW'(RETENTION - 1));

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state         <= IDLE;
         r_intervalCount <= '0;
         r_refreshRow    <= '0;
         r_outData       <= '0;
         r_outValid      <= 1'b0;
         r_dataLost      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i]    <= '0;
            r_age[i]     <= '0;
            r_expired[i] <= 1'b1;
         end
      end else begin
         r_intervalCount <= w_wrap ? '0 : r_intervalCount + IW'(1);

         case (r_state)
            IDLE: begin
               if (w_wrap && RefreshEnable) begin
                  r_state <= REFRESH;
               end
            end
            REFRESH: begin
               r_state      <= IDLE;
               r_refreshRow <= (r_refreshRow == AW'(DEPTH - 1)) ? '0 : r_refreshRow + AW'(1);
            end
            default: r_state <= IDLE;
         endcase

         r_outValid <= w_rdAccept;
         if (w_rdAccept) begin
            r_outData  <= w_rowLost ? '0 : r_data[Address];
            r_dataLost <= w_rowLost;
         end

         // Refresh restores charge only; a row already marked expired stays lost.
         for (int i = 0; i < DEPTH; i++) begin
            if (w_wrAccept && (Address == AW'(i))) begin
               r_data[i]    <= inputData;
               r_age[i]     <= '0;
               r_expired[i] <= 1'b0;
            end else if ((r_state == REFRESH) && (r_refreshRow == AW'(i))) begin
               r_age[i] <= '0;
            end else if (r_age[i] != AGW'(RETENTION)) begin
               r_age[i] <= r_age[i] + AGW'(1);
               if (r_age[i] == AGW'(RETENTION - 1)) begin
                  r_expired[i] <= 1'b1;
               end
            end
         end
      end
   end

   assign Ready         = w_ready;
   assign outputData    = r_outData;
   assign OutputValid   = r_outValid;
   assign DataLost      = r_dataLost;
   assign RefreshActive = (r_state == REFRESH);
   assign RefreshRow    = r_refreshRow;

endmodule

// File: tb/tb_qsram_array_refresh.sv
// Directed bench for qsram_array_refresh: a small 4-row array for refresh/retention timing
// and a default-sized array for data-path behaviour, sharing one set of inputs.
module tb_qsram_array_refresh;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       RefreshEnable;
   logic [3:0] Address;
   logic [7:0] inputData;
   logic       WriteEdge;
   logic       ReadEdge;

   logic       aReady, aOutputValid, aDataLost, aRefreshActive;
   logic [7:0] aOutputData;
   logic [1:0] aRefreshRow;
   logic       bReady, bOutputValid, bDataLost, bRefreshActive;
   logic [7:0] bOutputData;
   logic [3:0] bRefreshRow;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic       wr;
      logic       rd;
      logic [3:0] addr;
      logic [7:0] din;
      logic [7:0] expData;
      logic       expLost;
   } vec_t;

   vec_t vecs[13];

   qsram_array_refresh #(.WIDTH(8), .DEPTH(4), .REFRESH_INTERVAL(4), .RETENTION(32)) dutA (
      .Clock(Clock), .Reset(Reset), .RefreshEnable(RefreshEnable), .Address(Address[1:0]),
      .inputData(inputData), .WriteEdge(WriteEdge), .ReadEdge(ReadEdge), .Ready(aReady),
      .outputData(aOutputData), .OutputValid(aOutputValid), .DataLost(aDataLost),
      .RefreshActive(aRefreshActive), .RefreshRow(aRefreshRow)
   );

   qsram_array_refresh #(.WIDTH(8), .DEPTH(16), .REFRESH_INTERVAL(8), .RETENTION(256)) dutB (
      .Clock(Clock), .Reset(Reset), .RefreshEnable(RefreshEnable), .Address(Address),
      .inputData(inputData), .WriteEdge(WriteEdge), .ReadEdge(ReadEdge), .Ready(bReady),
      .outputData(bOutputData), .OutputValid(bOutputValid), .DataLost(bDataLost),
      .RefreshActive(bRefreshActive), .RefreshRow(bRefreshRow)
   );

   always #5 Clock = ~Clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic reportTimeout(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: wait bound expired, got timeout, expected event", name);
   endtask

   task automatic resetDuts(input logic en);
      Reset         = 1'b1;
      RefreshEnable = en;
      WriteEdge     = 1'b0;
      ReadEdge      = 1'b0;
      @(posedge Clock);
      #1;
      Reset = 1'b0;
   endtask

   task automatic waitReady(input bit useA, input string name);
      int n = 0;
      while (!(useA ? aReady : bReady) && n < 20) begin
         @(posedge Clock);
         #1;
         n++;
      end
      if (n >= 20) reportTimeout(name);
   endtask

   task automatic applyStimulus(input bit useA, input logic [3:0] addr, input logic [7:0] data);
      waitReady(useA, "writeReady");
      Address   = addr;
      inputData = data;
      WriteEdge = 1'b1;
      @(posedge Clock);
      #1;
      WriteEdge = 1'b0;
   endtask

   task automatic doRead(input bit useA, input logic [3:0] addr, input logic [7:0] expData,
                         input logic expLost, input string name);
      waitReady(useA, "readReady");
      Address  = addr;
      ReadEdge = 1'b1;
      @(posedge Clock);
      #1;
      ReadEdge = 1'b0;
      checkOutput({name, ".valid"}, useA ? aOutputValid : bOutputValid, 1);
      checkOutput({name, ".data"}, useA ? aOutputData : bOutputData, expData);
      checkOutput({name, ".lost"}, useA ? aDataLost : bDataLost, expLost);
   endtask

   initial begin
      Reset = 1'b1; RefreshEnable = 1'b0; Address = '0; inputData = '0;
      WriteEdge = 1'b0; ReadEdge = 1'b0;

      vecs[0]  = '{1'b0, 1'b1, 4'd3, 8'h00, 8'h00, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 4'd2, 8'hA5, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 4'd2, 8'h00, 8'hA5, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 4'd2, 8'h00, 8'hA5, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 4'd5, 8'h11, 8'hA5, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 4'd5, 8'h22, 8'h11, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 4'd5, 8'h00, 8'h22, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 4'd7, 8'h99, 8'h22, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 4'd7, 8'h00, 8'h99, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 4'd2, 8'h00, 8'hA5, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 4'd0, 8'h00, 8'h00, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 4'd0, 8'h5A, 8'h00, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 4'd0, 8'h00, 8'h5A, 1'b0};

      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
      checkOutput("rst.ready", bReady, 1);
      checkOutput("rst.refreshActive", bRefreshActive, 0);
      checkOutput("rst.refreshRow", bRefreshRow, 0);
      checkOutput("rst.outputData", bOutputData, 0);
      checkOutput("rst.outputValid", bOutputValid, 0);
      checkOutput("rst.dataLost", bDataLost, 0);

      // Data-path vectors on the large array with refresh suppressed (no stalls).
      for (int i = 0; i < 13; i++) begin
         Address   = vecs[i].addr;
         inputData = vecs[i].din;
         WriteEdge = vecs[i].wr;
         ReadEdge  = vecs[i].rd;
         @(posedge Clock);
         #1;
         WriteEdge = 1'b0;
         ReadEdge  = 1'b0;
         checkOutput($sformatf("vec%0d.valid", i), bOutputValid, vecs[i].rd);
         checkOutput($sformatf("vec%0d.data", i), bOutputData, vecs[i].expData);
         if (vecs[i].rd) checkOutput($sformatf("vec%0d.lost", i), bDataLost, vecs[i].expLost);
      end

      // Refresh slot cadence on the 4x4 array: slots in cycles 4,8,12,16,20.
      resetDuts(1'b1);
      for (int cyc = 1; cyc <= 21; cyc++) begin
         logic       expAct;
         logic [1:0] expRow;
         @(posedge Clock);
         #1;
         expAct = ((cyc % 4) == 0);
         expRow = 2'((cyc / 4 - 1) % 4);
         checkOutput($sformatf("slot%0d.active", cyc), aRefreshActive, expAct);
         checkOutput($sformatf("slot%0d.ready", cyc), aReady, !expAct);
         if (expAct) checkOutput($sformatf("slot%0d.row", cyc), aRefreshRow, expRow);
      end

      // A read held across the cycle-24 slot is accepted one cycle later.
      repeat (3) @(posedge Clock);
      #1;
      checkOutput("hold.inSlot", aRefreshActive, 1);
      Address  = 4'd1;
      ReadEdge = 1'b1;
      @(posedge Clock);
      #1;
      checkOutput("hold.ignored", aOutputValid, 0);
      @(posedge Clock);
      #1;
      ReadEdge = 1'b0;
      checkOutput("hold.valid", aOutputValid, 1);
      checkOutput("hold.data", aOutputData, 0);
      checkOutput("hold.lost", aDataLost, 1);

      // Retention with refresh suppressed: row survives 31 cycles, lost at 32.
      resetDuts(1'b0);
      applyStimulus(1'b1, 4'd1, 8'h3C);
      repeat (30) @(posedge Clock);
      #1;
      doRead(1'b1, 4'd1, 8'h3C, 1'b0, "ret31");
      doRead(1'b1, 4'd1, 8'h00, 1'b1, "ret32");

      // With refresh running the row survives far beyond RETENTION.
      resetDuts(1'b1);
      applyStimulus(1'b1, 4'd1, 8'h3C);
      repeat (200) @(posedge Clock);
      #1;
      doRead(1'b1, 4'd1, 8'h3C, 1'b0, "ret200");

      // Reset asserted during the second refresh slot of the large array.
      resetDuts(1'b1);
      applyStimulus(1'b0, 4'd4, 8'h77);
      begin
         int n = 0;
         while (!(bRefreshActive && bRefreshRow == 4'd1) && n < 40) begin
            @(posedge Clock);
            #1;
            n++;
         end
         if (n >= 40) reportTimeout("midRefresh.slot");
      end
      Reset = 1'b1;
      #1;
      checkOutput("midRst.ready", bReady, 1);
      checkOutput("midRst.active", bRefreshActive, 0);
      checkOutput("midRst.row", bRefreshRow, 0);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      doRead(1'b0, 4'd4, 8'h00, 1'b1, "midRst.row4");
      doRead(1'b0, 4'd9, 8'h00, 1'b1, "midRst.row9");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
